// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-channel round-robin arbiter.
package arb_pkg;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned DATA_W_DEF = 8;

    typedef logic [1:0] ch_idx_t;

    function automatic logic [NUM_CH-1:0] onehot4(input ch_idx_t idx);
        onehot4 = 4'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_8bit.sv
// Plain 4:1 mux of 8-bit words, select-driven.
module mux4_8bit (
    input  logic [1:0] sel_i,
    input  logic [7:0] d0_i,
    input  logic [7:0] d1_i,
    input  logic [7:0] d2_i,
    input  logic [7:0] d3_i,
    output logic [7:0] y_o
);

    always_comb begin
        y_o = d0_i;
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester after ptr, wrapping back to ptr.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  ch_idx_t           ptr_i,
    output ch_idx_t           gnt_idx_o,
    output logic              gnt_vld_o
);

    // Scan from lowest priority (ptr) up to highest (ptr+1); the last hit wins.
    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            ch_idx_t cand;
            cand = ptr_i + ch_idx_t'(k);
            if (req_i[cand]) begin
                gnt_idx_o = cand;
                gnt_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin 4:1 arbiter with a registered valid/ready output stage.
// Optional per-channel saturating grant counters when ARB_GRANT_CNT_EN is defined.
module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned RESET_PTR = 3
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef ARB_GRANT_CNT_EN
    output logic [NUM_CH*CNT_W-1:0]   grant_cnt,
    input  logic                      cnt_clr,
`endif
    input  logic [NUM_CH-1:0]         in_valid,
    input  logic [NUM_CH*DATA_W-1:0]  in_data,
    output logic [NUM_CH-1:0]         in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [1:0]                out_sel,
    input  logic                      out_ready
);

    if (RESET_PTR >= NUM_CH) begin : g_bad_ptr
        $error("RESET_PTR must be below NUM_CH");
    end
    if (CNT_W == 0) begin : g_bad_cnt
        $error("CNT_W must be non-zero");
    end

    ch_idx_t           ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    ch_idx_t           out_sel_q, out_sel_d;

    ch_idx_t           gnt_idx;
    logic              gnt_vld;
    logic              load_en;
    logic              grant;
    logic [DATA_W-1:0] mux_data;

    rr_pick4 u_pick (
        .req_i     (in_valid),
        .ptr_i     (ptr_q),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    if (DATA_W == 8) begin : g_mux8
        mux4_8bit u_mux (
            .sel_i (gnt_idx),
            .d0_i  (in_data[0*DATA_W +: DATA_W]),
            .d1_i  (in_data[1*DATA_W +: DATA_W]),
            .d2_i  (in_data[2*DATA_W +: DATA_W]),
            .d3_i  (in_data[3*DATA_W +: DATA_W]),
            .y_o   (mux_data)
        );
    end else begin : g_muxn
        assign mux_data = in_data[int'(gnt_idx)*DATA_W +: DATA_W];
    end

    // Slot free or draining this cycle; accept is suppressed while in reset.
    assign load_en  = ~out_valid_q | out_ready;
    assign grant    = load_en & gnt_vld & ~rst;
    assign in_ready = grant ? onehot4(gnt_idx) : '0;

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (grant) begin
            ptr_d       = gnt_idx;
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_sel_d   = gnt_idx;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= ch_idx_t'(RESET_PTR);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

`ifdef ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];

    // Saturating accept counters; clear takes priority over a same-cycle accept.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (in_ready[i] && in_valid[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt_out
        assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: reference arbitration model plus output monitor.
module tb_mux4_rr_arbiter;

    localparam int unsigned DW = 8;
`ifdef ARB_GRANT_CNT_EN
    localparam int unsigned CW = 4;
`else
    localparam int unsigned CW = 16;
`endif

    logic            clk;
    logic            rst;
    logic [3:0]      in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_sel;
    logic            out_ready;
`ifdef ARB_GRANT_CNT_EN
    logic [4*CW-1:0] grant_cnt;
    logic            cnt_clr;
`endif

    mux4_rr_arbiter #(.DATA_W(DW), .CNT_W(CW), .RESET_PTR(3)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ARB_GRANT_CNT_EN
        .grant_cnt (grant_cnt),
        .cnt_clr   (cnt_clr),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    sel;
        logic [DW-1:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    // Producer state: a channel keeps its word pending until it is accepted.
    logic [3:0]    pend;
    logic [DW-1:0] pdata [4];

    // Reference model state: who was granted last, and whether the output slot is full.
    int  last_g    = 3;
    bit  mdl_valid = 1'b0;
    bit  was_rst   = 1'b0;
    int  mdl_cnt [4];
    bit  clr_v     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int rr_next(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    // One clock cycle: drive at negedge+1, check in_ready at negedge+2, update the model.
    task automatic step(input bit r, input bit ordy);
        bit         load;
        int         g;
        logic [3:0] exp_rdy;
        @(negedge clk);
        #1;
`ifdef ARB_GRANT_CNT_EN
        for (int i = 0; i < 4; i++) begin
            check($sformatf("grant_cnt%0d", i), 32'(grant_cnt[i*CW +: CW]), 32'(mdl_cnt[i]));
        end
        cnt_clr = clr_v;
`endif
        rst       = r;
        out_ready = ordy;
        in_valid  = pend;
        for (int i = 0; i < 4; i++) in_data[i*DW +: DW] = pdata[i];
        #1;
        if (r) begin
            check("in_ready_in_reset", 32'(in_ready), 32'd0);
            sb.delete();
            mdl_valid = 1'b0;
            last_g    = 3;
            was_rst   = 1'b1;
            for (int i = 0; i < 4; i++) mdl_cnt[i] = 0;
        end else begin
            check("out_valid", 32'(out_valid), 32'(mdl_valid));
            if (was_rst) begin
                check("out_data_after_reset", 32'(out_data), 32'd0);
                check("out_sel_after_reset", 32'(out_sel), 32'd0);
            end
            was_rst = 1'b0;
            load    = !mdl_valid || ordy;
            g       = load ? rr_next(pend, last_g) : -1;
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (clr_v) begin
                for (int i = 0; i < 4; i++) mdl_cnt[i] = 0;
            end else if (g >= 0 && mdl_cnt[g] < (1 << CW) - 1) begin
                mdl_cnt[g]++;
            end
            if (g >= 0) begin
                sb.push_back({2'(g), pdata[g]});
                last_g    = g;
                mdl_valid = 1'b1;
                pend[g]   = 1'b0;
            end else if (load) begin
                mdl_valid = 1'b0;
            end
        end
    endtask

    task automatic refill(input int pct);
        for (int i = 0; i < 4; i++) begin
            if (!pend[i] && $urandom_range(99, 0) < pct) begin
                pend[i]  = 1'b1;
                pdata[i] = DW'($urandom);
            end
        end
    endtask

    task automatic set_all(input logic [3:0] mask, input logic [DW-1:0] base);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                pend[i]  = 1'b1;
                pdata[i] = base + DW'(i);
            end
        end
    endtask

    // Monitor: whenever a word is presented it must match the oldest expected word.
    always @(negedge clk) begin
        #3;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow actual=word %0h sel %0d required=no word", out_data, out_sel);
            end else begin
                check("out_data", 32'(out_data), 32'(sb[0].data));
                check("out_sel", 32'(out_sel), 32'(sb[0].sel));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        in_valid  = '0;
        in_data   = '0;
`ifdef ARB_GRANT_CNT_EN
        cnt_clr   = 1'b0;
`endif
        pend = '0;
        for (int i = 0; i < 4; i++) begin
            pdata[i]   = '0;
            mdl_cnt[i] = 0;
        end

        // Reset with arbitrary inputs, then a lone request from ch2.
        for (int c = 0; c < 2; c++) begin
            pend = 4'($urandom);
            for (int i = 0; i < 4; i++) pdata[i] = DW'($urandom);
            step(1'b1, 1'($urandom));
        end
        pend = '0;
        step(1'b0, 1'b1);
        pend     = 4'b0100;
        pdata[2] = 8'hA5;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // All channels requesting continuously, consumer always ready.
        step(1'b1, 1'b1);
        pend = '0;
        for (int c = 0; c < 10; c++) begin
            set_all(4'hF, 8'h10);
            step(1'b0, 1'b1);
        end

        // Backpressure for 5 cycles, then release.
        for (int c = 0; c < 5; c++) begin
            set_all(4'hF, 8'h20);
            step(1'b0, 1'b0);
        end
        for (int c = 0; c < 4; c++) begin
            set_all(4'hF, 8'h30);
            step(1'b0, 1'b1);
        end

        // Only ch1 and ch3, starting right after a ch1 grant.
        step(1'b1, 1'b1);
        pend = '0;
        set_all(4'b0010, 8'h40);
        step(1'b0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            set_all(4'b1010, 8'h50);
            step(1'b0, 1'b1);
        end

        // Reset while a word is stalled in the output stage.
        for (int c = 0; c < 3; c++) begin
            set_all(4'hF, 8'h60);
            step(1'b0, 1'b0);
        end
        step(1'b1, 1'b0);
        set_all(4'hF, 8'h70);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 800; c++) begin
            refill(55);
            step(($urandom_range(99, 0) < 1), ($urandom_range(3, 0) != 0));
        end

`ifdef ARB_GRANT_CNT_EN
        // Saturation of ch0 counter and clear against a concurrent grant.
        step(1'b1, 1'b1);
        pend = '0;
        for (int c = 0; c < 20; c++) begin
            set_all(4'b0001, 8'h80);
            step(1'b0, 1'b1);
        end
        set_all(4'b0001, 8'h90);
        clr_v = 1'b1;
        step(1'b0, 1'b1);
        clr_v = 1'b0;
        set_all(4'b0001, 8'hA0);
        step(1'b0, 1'b1);
`endif

        // Drain everything and confirm no word was lost.
        pend = '0;
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
